// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// MEM-stage data-memory access controller. It turns a load/store held by the
// MEM stage into a req/ack bus transaction and raises mem_stall_req while the
// access is outstanding. Load data comes back aligned and sign/zero extended.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   mem_en/we/size/     : access from the MEM stage (size 11 behaves as word)
//   mem_signed/addr/wdata
//   bus_req/we/addr/    : request side of the data bus; bus_req is held until
//   bus_be/bus_wdata      bus_ack or until the timeout abort
//   bus_ack/bus_rdata   : one-cycle completion pulse and the read word
//   mem_stall_req       : freeze request to the stall controller
//   mem_rdata           : last captured load result (0 for stores / aborts)
//   mem_done            : access completes this cycle
//   addr_err            : misaligned access (combinational, never issued)
//   bus_err             : timeout abort, valid together with mem_done
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        mem_stall_req,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        addr_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    // Registered copy of the access so the load extract does not depend on
    // the MEM-stage inputs staying stable through REQ.
    logic             r_bus_we;
    logic [31:0]      r_bus_addr;
    logic [3:0]       r_bus_be;
    logic [31:0]      r_bus_wdata;
    logic [1:0]       r_addr_lo;
    logic [1:0]       r_size;
    logic             r_signed;
    logic [31:0]      r_rdata;
    logic             r_bus_err;

    logic             w_is_half;
    logic             w_is_word;
    logic             w_addr_err;
    logic             w_accept;
    logic             w_timeout;
    logic             w_capture;
    logic             w_cap_err;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_shifted;
    logic [31:0]      w_load;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    assign w_is_half  = (mem_size == 2'b01);
    assign w_is_word  = mem_size[1];             // 10 and 11 are both word
    assign w_addr_err = mem_en & ((w_is_half & mem_addr[0]) |
                                  (w_is_word & (mem_addr[1:0] != 2'b00)));
    assign w_accept   = mem_en & ~w_addr_err;
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = mem_wdata;
        if (mem_size == 2'b00) begin
            w_be    = 4'b0001 << mem_addr[1:0];
            w_wdata = {4{mem_wdata[7:0]}};
        end else if (w_is_half) begin
            w_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{mem_wdata[15:0]}};
        end
    end

    // Load extract: bring the addressed lane down to bit 0, then extend.
    assign w_shifted = bus_rdata >> {r_addr_lo, 3'b000};

    always_comb begin
        w_load = w_shifted;
        if (r_size == 2'b00) begin
            w_load = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
        end else if (r_size == 2'b01) begin
            w_load = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_capture     = 1'b0;
        w_cap_err     = 1'b0;
        bus_req       = 1'b0;
        mem_stall_req = 1'b0;
        mem_done      = 1'b0;
        bus_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Stall in the same cycle so MEM/EX hold the inputs for us.
                mem_stall_req = w_accept;
                if (w_accept) begin
                    w_state_next = S_REQ;
                    w_cnt_next   = '0;
                end
            end
            S_REQ: begin
                bus_req       = 1'b1;
                mem_stall_req = 1'b1;
                w_cnt_next    = r_cnt + CNT_W'(1);
                // Ack wins over a timeout landing on the same cycle.
                if (bus_ack) begin
                    w_state_next = S_DONE;
                    w_capture    = 1'b1;
                end else if (w_timeout) begin
                    w_state_next = S_DONE;
                    w_capture    = 1'b1;
                    w_cap_err    = 1'b1;
                end
            end
            S_DONE: begin
                mem_done     = 1'b1;
                bus_err      = r_bus_err;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus request registers and result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
            r_addr_lo   <= '0;
            r_size      <= '0;
            r_signed    <= 1'b0;
            r_rdata     <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_accept) begin
                r_bus_we    <= mem_we;
                r_bus_addr  <= {mem_addr[31:2], 2'b00};
                r_bus_be    <= w_be;
                r_bus_wdata <= w_wdata;
                r_addr_lo   <= mem_addr[1:0];
                r_size      <= mem_size;
                r_signed    <= mem_signed;
            end
            if (w_capture) begin
                r_rdata   <= (w_cap_err || r_bus_we) ? 32'h0 : w_load;
                r_bus_err <= w_cap_err;
            end
        end
    end

    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;
    assign mem_rdata = r_rdata;
    assign addr_err  = w_addr_err;

endmodule
